// File: rtl/frac_clock_gen.sv
// -----------------------------------------------------------------------------
// frac_clock_gen
//
// Multi-channel fractional clock generator. Each channel adds a programmable
// increment to a phase accumulator every clk_src cycle. The accumulator MSB is
// the generated clock. The carry out of the add marks the falling edge. The
// average output frequency is f_src * inc / 2^ACC_BITS.
//
// Ports
//   clk_src    in   1         source clock, every register is on its rising edge
//   rst_n      in   1         synchronous active-low reset
//   ch_en      in   NUM_CH    per-channel run enable
//   sync       in   1         pulse: zero all accumulators on the same edge
//   cfg_valid  in   1         increment update request
//   cfg_ready  out  1         update for cfg_ch can be accepted this cycle
//   cfg_ch     in   CH_W      target channel of the update
//   cfg_inc    in   ACC_BITS  new increment, clamped to 2^(ACC_BITS-1)
//   clk_out    out  NUM_CH    generated clocks (accumulator MSB, registered)
//   rise_ce    out  NUM_CH    one-cycle pulse in the cycle clk_out becomes 1
//   fall_ce    out  NUM_CH    one-cycle pulse in the cycle clk_out becomes 0
//
// When clk_out is used as a real clock, route it through a global buffer.
// -----------------------------------------------------------------------------
module frac_clock_gen #(
  parameter int          NUM_CH      = 2,
  parameter int          ACC_BITS    = 24,
  parameter int unsigned INC_DEFAULT = 480439,
  localparam int         CH_W        = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_src,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_BITS-1:0] cfg_inc,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   rise_ce,
  output logic [NUM_CH-1:0]   fall_ce
);

  // Largest legal increment. It caps the output at f_src/2, so the MSB
  // changes at most once per cycle. Because of this cap, rise and fall never
  // happen on the same edge.
  localparam logic [ACC_BITS-1:0] HALF = {1'b1, {(ACC_BITS-1){1'b0}}};

  localparam logic [ACC_BITS-1:0] INC_RST =
    (64'(INC_DEFAULT) > (64'd1 << (ACC_BITS-1))) ? HALF : ACC_BITS'(INC_DEFAULT);

  function automatic logic [ACC_BITS-1:0] clamp_inc(input logic [ACC_BITS-1:0] v);
    return (v > HALF) ? HALF : v;
  endfunction

  // Update handshake: a transfer happens on a rising edge where
  // cfg_valid && cfg_ready. The requester holds cfg_valid, cfg_ch and cfg_inc
  // stable until that edge. cfg_ready depends only on cfg_ch and the pending
  // flags, never on cfg_valid. A channel holding an unapplied update
  // (pending=1) refuses new updates. An out-of-range channel is always ready
  // and its data is dropped.
  logic [NUM_CH-1:0] pending;

  always_comb begin
    cfg_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == CH_W'(c)) cfg_ready = ~pending[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_BITS-1:0] acc_q;
    logic [ACC_BITS-1:0] inc_q;
    logic [ACC_BITS-1:0] shadow_q;
    logic                pending_q;
    logic                rise_q;
    logic                fall_q;
    logic [ACC_BITS:0]   sum;
    logic                take;

    assign sum  = {1'b0, acc_q} + {1'b0, inc_q};
    assign take = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));

    always_ff @(posedge clk_src) begin
      if (!rst_n) begin
        acc_q     <= '0;
        inc_q     <= INC_RST;
        shadow_q  <= INC_RST;
        pending_q <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync) begin
          // Phase alignment. A channel that was high gets its falling edge
          // now. Any waiting update takes effect from phase zero.
          acc_q  <= '0;
          fall_q <= acc_q[ACC_BITS-1];
          if (pending_q) begin
            inc_q     <= shadow_q;
            pending_q <= 1'b0;
          end
        end else if (!ch_en[c]) begin
          // Parked at phase zero. There is no wrap to wait for, so an update
          // is applied right away.
          acc_q <= '0;
          if (pending_q) begin
            inc_q     <= shadow_q;
            pending_q <= 1'b0;
          end
        end else begin
          acc_q  <= sum[ACC_BITS-1:0];
          rise_q <= sum[ACC_BITS-1] & ~acc_q[ACC_BITS-1];
          fall_q <= sum[ACC_BITS];
          // The new increment switches in at the wrap. This edge still uses
          // the old increment, so the current period is not cut short.
          if (sum[ACC_BITS] && pending_q) begin
            inc_q     <= shadow_q;
            pending_q <= 1'b0;
          end
        end
        // take requires pending_q == 0, so it never collides with an apply.
        if (take) begin
          shadow_q  <= clamp_inc(cfg_inc);
          pending_q <= 1'b1;
        end
      end
    end

    assign clk_out[c] = acc_q[ACC_BITS-1];
    assign rise_ce[c] = rise_q;
    assign fall_ce[c] = fall_q;
    assign pending[c] = pending_q;
  end

endmodule
